regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with self-clearing FSM; x0 hard-wired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_req,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            ready
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx, clr_idx_nxt;
  logic            ready_nxt;
  logic            wr_en;
  logic [XLEN-1:0] regs [NREGS];

  // A clear request in the same cycle pre-empts any write.
  assign wr_en = (state == READY) && we && (waddr != '0) && !clr_req && !reset;

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (addr == waddr)) val = wdata;
`endif
    if (!ready || reset || (addr == '0)) val = '0;
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      ready   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ready_nxt   = ready;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == AW'(NREGS - 1)) begin
          state_nxt   = READY;
          ready_nxt   = 1'b1;
          clr_idx_nxt = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
          ready_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_idx_nxt = '0;
        ready_nxt   = 1'b0;
      end
    endcase
  end

  // Storage is not reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        regs[clr_idx] <= '0;
      else if (wr_en)
        regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 64-bit x 32 configuration).
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clr_req = 1'b0;
  logic            we = 1'b0;
  logic [AW-1:0]   waddr = '0;
  logic [XLEN-1:0] wdata = '0;
  logic [AW-1:0]   raddr1 = '0;
  logic [AW-1:0]   raddr2 = '0;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            ready;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
    .rdata2(rdata2), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; raddr1 = 5'd3; raddr2 = 5'd0;
    step();
    total++;
    if (ready !== 1'b0 || rdata1 !== '0) begin
      bad++;
      $display("FAIL reset_state ready=%b rdata1=%h required ready=0 rdata1=0", ready, rdata1);
    end
    reset = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      step();
      total++;
      if (ready !== (k == NREGS)) begin
        bad++;
        $display("FAIL reset_ready_edge%0d ready=%b required %b", k, ready, (k == NREGS));
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(NREGS - 1 - i);
      #1;
      total++;
      if (rdata1 !== '0 || rdata2 !== '0) begin
        bad++;
        $display("FAIL reset_zero_x%0d rdata1=%h rdata2=%h required 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    raddr1 = 5'd1; raddr2 = 5'd2;
    write_reg(5'd5, 64'hDEADBEEF_CAFEF00D);
    write_reg(5'd31, 64'h0123_4567_89AB_CDEF);
    raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 64'hDEADBEEF_CAFEF00D || rdata2 !== 64'hDEADBEEF_CAFEF00D) begin
      bad++;
      $display("FAIL rw_x5 rdata1=%h rdata2=%h required deadbeefcafef00d", rdata1, rdata2);
    end
    raddr1 = 5'd31; raddr2 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 64'h0123_4567_89AB_CDEF || rdata2 !== 64'hDEADBEEF_CAFEF00D) begin
      bad++;
      $display("FAIL rw_x31 rdata1=%h rdata2=%h required 0123456789abcdef/deadbeefcafef00d",
               rdata1, rdata2);
    end
  endtask

  task automatic test_zero_reg();
    raddr1 = 5'd0; raddr2 = 5'd0;
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    total++;
    if (rdata1 !== '0) begin
      bad++;
      $display("FAIL x0_same_cycle rdata1=%h required 0", rdata1);
    end
    step();
    we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdata1 !== '0 || rdata2 !== '0) begin
        bad++;
        $display("FAIL x0_after_write rdata1=%h rdata2=%h required 0", rdata1, rdata2);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp7;
    write_reg(5'd10, 64'h1);
    write_reg(5'd10, 64'h2);
    write_reg(5'd7, 64'hAAAA);
    raddr1 = 5'd10; raddr2 = 5'd7;
    #1;
    total++;
    if (rdata1 !== 64'h2 || rdata2 !== 64'hAAAA) begin
      bad++;
      $display("FAIL b2b rdata1=%h rdata2=%h required 2/aaaa", rdata1, rdata2);
    end
    // Same-cycle write with read of the same register.
    we = 1'b1; waddr = 5'd7; wdata = 64'h1234; raddr1 = 5'd7; raddr2 = 5'd10;
`ifdef REGFILE_BYPASS_EN
    exp7 = 64'h1234;
`else
    exp7 = 64'hAAAA;
`endif
    #1;
    total++;
    if (rdata1 !== exp7 || rdata2 !== 64'h2) begin
      bad++;
      $display("FAIL bypass_x7 rdata1=%h rdata2=%h required %h/2", rdata1, rdata2, exp7);
    end
    step();
    we = 1'b0;
    total++;
    if (rdata1 !== 64'h1234) begin
      bad++;
      $display("FAIL bypass_x7_after rdata1=%h required 1234", rdata1);
    end
  endtask

  task automatic test_clear();
    write_reg(5'd3, 64'h55);
    write_reg(5'd4, 64'h77);
    clr_req = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 64'h66; raddr1 = 5'd4; raddr2 = 5'd3;
    #1;
    total++;
    if (rdata1 !== 64'h77 || rdata2 !== 64'h55) begin
      bad++;
      $display("FAIL clr_no_bypass rdata1=%h rdata2=%h required 77/55", rdata1, rdata2);
    end
    step();
    clr_req = 1'b0; we = 1'b0;
    total++;
    if (ready !== 1'b0 || rdata2 !== '0) begin
      bad++;
      $display("FAIL clr_enter ready=%b rdata2=%h required 0/0", ready, rdata2);
    end
    for (int k = 1; k <= NREGS; k++) begin
      clr_req = (k == 5);
      we = (k == NREGS); waddr = 5'd9; wdata = 64'h99;
      step();
      total++;
      if (ready !== (k == NREGS)) begin
        bad++;
        $display("FAIL clr_ready_edge%0d ready=%b required %b", k, ready, (k == NREGS));
      end
    end
    clr_req = 1'b0; we = 1'b0;
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    total++;
    if (rdata1 !== '0 || rdata2 !== '0) begin
      bad++;
      $display("FAIL clr_x3_x4 rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    raddr1 = 5'd9; raddr2 = 5'd5;
    #1;
    total++;
    if (rdata1 !== '0 || rdata2 !== '0) begin
      bad++;
      $display("FAIL clr_x9_x5 rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
  endtask

  task automatic test_reset_mid_clear();
    write_reg(5'd12, 64'hC0FFEE);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    reset = 1'b1; raddr1 = 5'd12;
    step();
    total++;
    if (ready !== 1'b0 || rdata1 !== '0) begin
      bad++;
      $display("FAIL midclr_reset ready=%b rdata1=%h required 0/0", ready, rdata1);
    end
    reset = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      step();
      total++;
      if (ready !== (k == NREGS)) begin
        bad++;
        $display("FAIL midclr_ready_edge%0d ready=%b required %b", k, ready, (k == NREGS));
      end
    end
    total++;
    if (rdata1 !== '0) begin
      bad++;
      $display("FAIL midclr_x12 rdata1=%h required 0", rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
